// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int ITERS = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rsData,
  input  logic [WIDTH-1:0] rtData,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FIXUP = 2'd2
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   opnd_reg;
  logic               is_div_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               div_zero_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;

  logic               op_signed;
  logic [WIDTH-1:0]   abs_rs;
  logic [WIDTH-1:0]   abs_rt;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_signed = ~op[0];
  assign abs_rs    = (op_signed && rsData[WIDTH-1]) ? -rsData : rsData;
  assign abs_rt    = (op_signed && rtData[WIDTH-1]) ? -rtData : rtData;

  // Multiply adds into the upper half; divide trial-subtracts {rem, next dividend bit}.
  assign sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opnd_reg};
  assign diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_reg};

  assign prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
  assign quot_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
  assign rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      opnd_reg     <= '0;
      is_div_reg   <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      hi_reg       <= '0;
      lo_reg       <= '0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && !cancel) begin
            state_reg    <= ITER;
            busy_reg     <= 1'b1;
            cnt_reg      <= '0;
            is_div_reg   <= op[1];
            sign_a_reg   <= op_signed & rsData[WIDTH-1];
            sign_b_reg   <= op_signed & rtData[WIDTH-1];
            div_zero_reg <= (rtData == '0);
            // Multiply: multiplier sits in the low half; divide: dividend does.
            acc_reg      <= {{WIDTH{1'b0}}, op[1] ? abs_rs : abs_rt};
            opnd_reg     <= op[1] ? abs_rt : abs_rs;
          end else if (!start) begin
            if (mthi) hi_reg <= rsData;
            if (mtlo) lo_reg <= rsData;
          end
        end
        ITER: begin
          if (cancel) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            if (is_div_reg) begin
              if (!diff[WIDTH]) acc_reg <= {diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};
              else              acc_reg <= {acc_reg[2*WIDTH-2:0], 1'b0};
            end else if (acc_reg[0]) begin
              acc_reg <= {sum, acc_reg[WIDTH-1:1]};
            end else begin
              acc_reg <= {1'b0, acc_reg[2*WIDTH-1:1]};
            end
            cnt_reg <= cnt_reg + 1'b1;
            if (cnt_reg == LAST_ITER) state_reg <= FIXUP;
          end
        end
        FIXUP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!cancel) begin
            done_reg <= 1'b1;
            if (is_div_reg) begin
              // A zero divisor leaves the dividend in the remainder; restoring its sign gives rsData back.
              hi_reg <= rem_fix;
              lo_reg <= div_zero_reg ? {WIDTH{1'b1}} : quot_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule
